// File: rtl/dom_mul_gf2_sched_if.sv
// Bus between the requesters (masked S-box / inversion stages) and the
// GF(2^2) multiplier scheduler. Requesters use the master modport, the
// scheduler uses the slave modport.
interface dom_mul_gf2_sched_if #(
    parameter int SHARES = 2,
    parameter int NREQ   = 4,
    parameter int LFSR_W = 32
);
    logic [NREQ-1:0]          ReqxSI;
    logic [NREQ*2*SHARES-1:0] XxDI;
    logic [NREQ*2*SHARES-1:0] YxDI;
    logic [NREQ-1:0]          GntxSO;
    logic                     ReadyxSO;
    logic [2*SHARES-1:0]      QxDO;
    logic [NREQ-1:0]          QValidxSO;
    logic [LFSR_W-1:0]        SeedxDI;
    logic                     SeedLdxSI;

    modport master (
        output ReqxSI, XxDI, YxDI, SeedxDI, SeedLdxSI,
        input  GntxSO, ReadyxSO, QxDO, QValidxSO
    );

    modport slave (
        input  ReqxSI, XxDI, YxDI, SeedxDI, SeedLdxSI,
        output GntxSO, ReadyxSO, QxDO, QValidxSO
    );
endinterface

// File: rtl/dom_mul_gf2_sched.sv
// dom_mul_gf2_sched: time-multiplexes one pipelined DOM GF(2^2) multiplier
// among NREQ requesters. Granted operand shares are registered together with
// fresh randomness from an internal Galois LFSR; the masked product returns
// to its owner exactly two edges after the grant cycle.
// GF(2^2) uses the polynomial basis with x^2 = x + 1; element bit 1 is the
// coefficient of x. Share s of an operand occupies bits [2s+1:2s].
// Optional feature: define DOM_MUL_SCHED_RR_EN for round-robin arbitration;
// without it the lowest requesting index wins.

// Pipelined domain-oriented masked multiplier in GF(2^2).
module shared_mul_gf2 #(
    parameter int SHARES    = 2,
    parameter int PIPELINED = 1
) (
    input  logic                          ClkxCI,
    input  logic                          RstxRI,
    input  logic [2*SHARES-1:0]           XxDI,
    input  logic [2*SHARES-1:0]           YxDI,
    input  logic [SHARES*(SHARES-1)-1:0]  ZxDI,
    output logic [2*SHARES-1:0]           QxDO
);
    function automatic logic [1:0] gfMul(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
                (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    // Position of the shared random for unordered share pair (i,j).
    function automatic int pairIdx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    logic [1:0] termD [SHARES][SHARES];
    logic [1:0] termQ [SHARES][SHARES];

    // Inner-domain products and cross-domain products blinded with Z.
    always_comb begin
        termD = '{default: '0};
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                if (i == j) begin
                    termD[i][j] = gfMul(XxDI[2*i +: 2], YxDI[2*i +: 2]);
                end else begin
                    termD[i][j] = gfMul(XxDI[2*i +: 2], YxDI[2*j +: 2])
                                ^ ZxDI[2*pairIdx(i, j) +: 2];
                end
            end
        end
    end

    generate
        if (PIPELINED != 0) begin : gPipe
            // Register every term before recombination so blinded cross terms never glitch together.
            always_ff @(posedge ClkxCI or posedge RstxRI) begin
                if (RstxRI) begin
                    termQ <= '{default: '0};
                end else begin
                    termQ <= termD;
                end
            end
        end else begin : gComb
            // Combinational variant, kept for drop-in compatibility.
            always_comb begin
                termQ = termD;
            end
        end
    endgenerate

    // Each output share is the XOR of its own domain's registered terms.
    always_comb begin
        QxDO = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                QxDO[2*i +: 2] = QxDO[2*i +: 2] ^ termQ[i][j];
            end
        end
    end
endmodule

module dom_mul_gf2_sched #(
    parameter int                SHARES     = 2,
    parameter int                NREQ       = 4,
    parameter int                LFSR_W     = 32,
    parameter logic [LFSR_W-1:0] LFSR_POLY  = 32'h80200003,
    parameter logic [LFSR_W-1:0] LFSR_INIT  = 32'hACE1_2468,
    parameter int                WARMUP_CYC = 16
) (
    input  logic                 ClkxCI,
    input  logic                 RstxRI,
    dom_mul_gf2_sched_if.slave   bus
);
    localparam int SW = 2 * SHARES;
    localparam int ZW = SHARES * (SHARES - 1);
    localparam int TW = $clog2(NREQ);
    localparam int CW = $clog2(WARMUP_CYC + 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(WARMUP_CYC - 1);

    typedef enum logic {WARMUP, RUN} stateT;

    stateT             stateQ;
    logic [CW-1:0]     cntQ;
    logic              readyQ;
    logic [LFSR_W-1:0] lfsrQ;

    logic [NREQ-1:0]   reqEff;
    logic              gntValid;
    logic [TW-1:0]     gntIdx;
    logic [SW-1:0]     xSel;
    logic [SW-1:0]     ySel;

    logic [SW-1:0]     xQ;
    logic [SW-1:0]     yQ;
    logic [ZW-1:0]     zQ;
    logic [TW-1:0]     tag1Q;
    logic              v1Q;
    logic [TW-1:0]     tag2Q;
    logic              v2Q;
    logic [SW-1:0]     mulQ;

`ifdef DOM_MUL_SCHED_RR_EN
    logic [TW-1:0]     ptrQ;

    // Round-robin pick: search upward from the pointer, wrapping at NREQ.
    always_comb begin
        int c;
        c        = 0;
        reqEff   = (stateQ == RUN && !bus.SeedLdxSI) ? bus.ReqxSI : '0;
        gntValid = 1'b0;
        gntIdx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptrQ) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!gntValid && reqEff[c]) begin
                gntValid = 1'b1;
                gntIdx   = c[TW-1:0];
            end
        end
    end

    // Advance the pointer past the requester just served.
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            ptrQ <= '0;
        end else if (gntValid) begin
            ptrQ <= (gntIdx == TW'(NREQ - 1)) ? '0 : gntIdx + TW'(1);
        end
    end
`else
    // Fixed priority pick: lowest requesting index wins.
    always_comb begin
        reqEff   = (stateQ == RUN && !bus.SeedLdxSI) ? bus.ReqxSI : '0;
        gntValid = 1'b0;
        gntIdx   = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (!gntValid && reqEff[r]) begin
                gntValid = 1'b1;
                gntIdx   = r[TW-1:0];
            end
        end
    end
`endif

    // Route the granted requester's shares; all-zero when nobody is granted.
    always_comb begin
        xSel = '0;
        ySel = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (gntValid && gntIdx == TW'(r)) begin
                xSel = bus.XxDI[r*SW +: SW];
                ySel = bus.YxDI[r*SW +: SW];
            end
        end
    end

    assign bus.GntxSO = gntValid ? (NREQ'(1) << gntIdx) : '0;

    // Warm-up / run control; a reseed always forces a fresh warm-up.
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            stateQ <= WARMUP;
            cntQ   <= CNT_RELOAD;
            readyQ <= 1'b0;
        end else begin
            case (stateQ)
                WARMUP: begin
                    if (bus.SeedLdxSI) begin
                        cntQ <= CNT_RELOAD;
                    end else if (cntQ == '0) begin
                        stateQ <= RUN;
                        readyQ <= 1'b1;
                    end else begin
                        cntQ <= cntQ - CW'(1);
                    end
                end
                RUN: begin
                    if (bus.SeedLdxSI) begin
                        stateQ <= WARMUP;
                        cntQ   <= CNT_RELOAD;
                        readyQ <= 1'b0;
                    end
                end
                default: begin
                    stateQ <= WARMUP;
                    cntQ   <= CNT_RELOAD;
                    readyQ <= 1'b0;
                end
            endcase
        end
    end

    // Galois LFSR for mask randomness; a zero seed would lock it, so fall back to the init value.
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            lfsrQ <= LFSR_INIT;
        end else if (bus.SeedLdxSI) begin
            lfsrQ <= (bus.SeedxDI == '0) ? LFSR_INIT : bus.SeedxDI;
        end else begin
            lfsrQ <= (lfsrQ >> 1) ^ (lfsrQ[0] ? LFSR_POLY : '0);
        end
    end

    // Stage 1: capture granted operands with the grant cycle's randomness.
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            xQ    <= '0;
            yQ    <= '0;
            zQ    <= '0;
            tag1Q <= '0;
            v1Q   <= 1'b0;
        end else begin
            xQ    <= xSel;
            yQ    <= ySel;
            zQ    <= gntValid ? lfsrQ[ZW-1:0] : '0;
            tag1Q <= gntIdx;
            v1Q   <= gntValid;
        end
    end

    // Stage 2: delay owner tag alongside the multiplier's internal registers.
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            tag2Q <= '0;
            v2Q   <= 1'b0;
        end else begin
            tag2Q <= tag1Q;
            v2Q   <= v1Q;
        end
    end

    shared_mul_gf2 #(
        .SHARES    (SHARES),
        .PIPELINED (1)
    ) uMul (
        .ClkxCI (ClkxCI),
        .RstxRI (RstxRI),
        .XxDI   (xQ),
        .YxDI   (yQ),
        .ZxDI   (zQ),
        .QxDO   (mulQ)
    );

    assign bus.QxDO      = v2Q ? mulQ : '0;
    assign bus.QValidxSO = v2Q ? (NREQ'(1) << tag2Q) : '0;
    assign bus.ReadyxSO  = readyQ;
endmodule

// File: tb/tb_dom_mul_gf2_sched.sv
// Directed testbench for dom_mul_gf2_sched (default parameters, SHARES=2,
// NREQ=4). Expected products come from a hand-written GF(2^2) table.
module tb_dom_mul_gf2_sched;
    localparam int          SHARES = 2;
    localparam int          NREQ   = 4;
    localparam int          LFSR_W = 32;
    localparam logic [31:0] POLY   = 32'h80200003;
    localparam logic [31:0] INIT   = 32'hACE1_2468;

    logic ClkxCI = 1'b0;
    logic RstxRI;

    always #5 ClkxCI = ~ClkxCI;

    dom_mul_gf2_sched_if #(.SHARES(SHARES), .NREQ(NREQ), .LFSR_W(LFSR_W)) bus ();

    dom_mul_gf2_sched #(
        .SHARES (SHARES),
        .NREQ   (NREQ),
        .LFSR_W (LFSR_W)
    ) dut (
        .ClkxCI (ClkxCI),
        .RstxRI (RstxRI),
        .bus    (bus)
    );

    int assertCount = 0;
    int failCount   = 0;

    logic [1:0]  golden [16];
    logic [31:0] modelLfsr;

    function automatic logic [31:0] lfsrStep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    function automatic logic [1:0] unmask(input logic [3:0] q);
        return q[1:0] ^ q[3:2];
    endfunction

    // Reference LFSR, following reset, reseed and free-running steps.
    always @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            modelLfsr <= INIT;
        end else if (bus.SeedLdxSI) begin
            modelLfsr <= (bus.SeedxDI == 32'h0) ? INIT : bus.SeedxDI;
        end else begin
            modelLfsr <= lfsrStep(modelLfsr);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge ClkxCI);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic seedLd, input logic [31:0] seed);
        bus.ReqxSI    = req;
        bus.SeedLdxSI = seedLd;
        bus.SeedxDI   = seed;
    endtask

    task automatic setOperand(input int r, input logic [1:0] x, input logic [1:0] y);
        logic [1:0] mx;
        logic [1:0] my;
        mx = 2'($urandom_range(0, 3));
        my = 2'($urandom_range(0, 3));
        bus.XxDI[r*4 +: 4] = {x ^ mx, mx};
        bus.YxDI[r*4 +: 4] = {y ^ my, my};
    endtask

    // Count cycles with ReadyxSO low (bounded) and collect any grants seen meanwhile.
    task automatic waitReady(input string tag, input int expCycles, output logic [3:0] gntSeen);
        int low;
        low     = 0;
        gntSeen = '0;
        while (!bus.ReadyxSO && low < 64) begin
            #2;
            gntSeen = gntSeen | bus.GntxSO;
            low++;
            stepCycle();
        end
        checkOutput(tag, 64'(low), 64'(expCycles));
    endtask

    initial begin
        logic [3:0] gntSeen;
        logic [3:0] expSeq [10];
        logic [3:0] pv;
        logic [1:0] zA;
        logic [1:0] zB;
        logic [1:0] zExp;
        logic [31:0] s;

        golden = '{2'd0, 2'd0, 2'd0, 2'd0,
                   2'd0, 2'd1, 2'd2, 2'd3,
                   2'd0, 2'd2, 2'd3, 2'd1,
                   2'd0, 2'd3, 2'd1, 2'd2};

        RstxRI   = 1'b1;
        bus.XxDI = 16'($urandom());
        bus.YxDI = 16'($urandom());
        applyStimulus(4'b1111, 1'b0, 32'h0);

        // Reset values
        #12;
        checkOutput("rstGnt",    64'(bus.GntxSO),    64'h0);
        checkOutput("rstReady",  64'(bus.ReadyxSO),  64'h0);
        checkOutput("rstQValid", 64'(bus.QValidxSO), 64'h0);
        checkOutput("rstQ",      64'(bus.QxDO),      64'h0);

        // Warm-up after reset release, all requesters asking
        stepCycle();
        RstxRI = 1'b0;
        waitReady("readyAfterReset", 16, gntSeen);
        checkOutput("gntDuringWarmup", 64'(gntSeen), 64'h0);

        // Arbitration sequence with all four requesting for 8 cycles
        for (int c = 0; c < 10; c++) begin
`ifdef DOM_MUL_SCHED_RR_EN
            expSeq[c] = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
`else
            expSeq[c] = (c < 8) ? 4'b0001 : 4'b0000;
`endif
        end
        for (int c = 0; c < 10; c++) begin
            applyStimulus((c < 8) ? 4'b1111 : 4'b0000, 1'b0, 32'h0);
            #2;
            checkOutput($sformatf("arbGnt%0d", c), 64'(bus.GntxSO), 64'(expSeq[c]));
            if (c >= 2) begin
                checkOutput($sformatf("arbQValid%0d", c), 64'(bus.QValidxSO), 64'(expSeq[c-2]));
            end
            stepCycle();
        end

        // All 16 unmasked operand pairs through requester 1
        for (int p = 0; p < 16; p++) begin
            pv       = p[3:0];
            bus.XxDI = 16'($urandom());
            bus.YxDI = 16'($urandom());
            setOperand(1, pv[3:2], pv[1:0]);
            applyStimulus(4'b0010, 1'b0, 32'h0);
            #2;
            checkOutput($sformatf("mulGnt%0d", p), 64'(bus.GntxSO), 64'h2);
            stepCycle();
            applyStimulus(4'b0000, 1'b0, 32'h0);
            #2;
            checkOutput($sformatf("mulIdle%0d", p), 64'(bus.QValidxSO), 64'h0);
            stepCycle();
            #2;
            checkOutput($sformatf("mulQValid%0d", p), 64'(bus.QValidxSO), 64'h2);
            checkOutput($sformatf("mulProd%0d", p), 64'(unmask(bus.QxDO)), 64'(golden[p]));
            stepCycle();
        end

        // Back-to-back grants with zero operands expose the captured Z on both shares
        bus.XxDI = '0;
        bus.YxDI = '0;
        applyStimulus(4'b0100, 1'b0, 32'h0);
        zA = modelLfsr[1:0];
        #2;
        checkOutput("b2bGntA", 64'(bus.GntxSO), 64'h4);
        stepCycle();
        applyStimulus(4'b1000, 1'b0, 32'h0);
        zB = modelLfsr[1:0];
        #2;
        checkOutput("b2bGntB", 64'(bus.GntxSO), 64'h8);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 32'h0);
        #2;
        checkOutput("b2bQValidA", 64'(bus.QValidxSO), 64'h4);
        checkOutput("b2bZA",      64'(bus.QxDO),      64'({zA, zA}));
        stepCycle();
        #2;
        checkOutput("b2bQValidB", 64'(bus.QValidxSO), 64'h8);
        checkOutput("b2bZB",      64'(bus.QxDO),      64'({zB, zB}));
        stepCycle();

        // Zero seed in RUN one cycle after a grant
        setOperand(0, 2'd3, 2'd2);
        applyStimulus(4'b0001, 1'b0, 32'h0);
        #2;
        checkOutput("seedGnt", 64'(bus.GntxSO), 64'h1);
        stepCycle();
        applyStimulus(4'b1111, 1'b1, 32'h0);
        #2;
        checkOutput("seedGntGated", 64'(bus.GntxSO), 64'h0);
        stepCycle();
        applyStimulus(4'b1111, 1'b0, 32'h0);
        #2;
        checkOutput("seedQValid", 64'(bus.QValidxSO), 64'h1);
        checkOutput("seedProd",   64'(unmask(bus.QxDO)), 64'h1);
        waitReady("readyAfterSeed", 16, gntSeen);
        checkOutput("gntDuringReseed", 64'(gntSeen), 64'h0);
        s = INIT;
        for (int k = 0; k < 16; k++) begin
            s = lfsrStep(s);
        end
        zExp     = s[1:0];
        bus.XxDI = '0;
        bus.YxDI = '0;
        applyStimulus(4'b0001, 1'b0, 32'h0);
        #2;
        checkOutput("seedZGnt", 64'(bus.GntxSO), 64'h1);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 32'h0);
        stepCycle();
        #2;
        checkOutput("seedZQValid", 64'(bus.QValidxSO), 64'h1);
        checkOutput("seedZ",       64'(bus.QxDO),      64'({zExp, zExp}));
        stepCycle();

        // Reset pulse in the cycle after a grant drops the in-flight op
        setOperand(0, 2'd2, 2'd2);
        applyStimulus(4'b0001, 1'b0, 32'h0);
        #2;
        checkOutput("rstOpGnt", 64'(bus.GntxSO), 64'h1);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 32'h0);
        RstxRI = 1'b1;
        #2;
        RstxRI = 1'b0;
        checkOutput("rstOpReady", 64'(bus.ReadyxSO), 64'h0);
        gntSeen = '0;
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            #2;
            gntSeen = gntSeen | bus.QValidxSO;
            checkOutput($sformatf("rstOpQ%0d", k), 64'(bus.QxDO), 64'h0);
        end
        checkOutput("rstOpQValid", 64'(gntSeen), 64'h0);
        checkOutput("rstOpWarmup", 64'(bus.ReadyxSO), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
